// File: rtl/aes_encrypt_arbiter.sv
// Round-robin front end that shares one byte-serial AES-128 core among N_REQ requesters.
// It streams key/plaintext bytes in, collects 16 ciphertext bytes and returns them on a valid/ready port.
module aes_encrypt_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1023,
  localparam int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*128-1:0]   req_key,
  input  logic [N_REQ*128-1:0]   req_pt,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           rsp_ct,
  output logic                   rsp_err,
  output logic                   core_en,
  output logic [7:0]             core_key_byte,
  output logic [7:0]             core_state_byte,
  input  logic                   core_ready,
  input  logic [7:0]             core_out_byte
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0] LOAD_LAST = 5'd16;
  localparam logic [4:0] UNLOAD_LAST = 5'd15;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, RESP} stateType;

  stateType          state;
  stateType          stateNext;
  logic [ID_W-1:0]   rrPtr;
  logic [127:0]      keyLat;
  logic [127:0]      ptLat;
  logic [4:0]        cnt;
  logic [TMR_W-1:0]  timer;
  logic              timerDone;
  logic [3:0]        byteIdx;

  logic              foundHi;
  logic              foundLo;
  logic [ID_W-1:0]   hiId;
  logic [ID_W-1:0]   loId;
  logic              grantFound;
  logic [ID_W-1:0]   grantId;
  logic [ID_W-1:0]   rrNext;
  logic [N_REQ-1:0]  grantOneHot;
  logic [127:0]      selKey;
  logic [127:0]      selPt;

  // Round-robin pick: first requester at or above rrPtr, else the lowest one overall.
  always_comb begin
    foundHi     = 1'b0;
    foundLo     = 1'b0;
    hiId        = '0;
    loId        = '0;
    selKey      = '0;
    selPt       = '0;
    grantOneHot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!foundHi && req_valid[i] && (ID_W'(i) >= rrPtr)) begin
        foundHi = 1'b1;
        hiId    = ID_W'(i);
      end
      if (!foundLo && req_valid[i]) begin
        foundLo = 1'b1;
        loId    = ID_W'(i);
      end
    end
    grantFound = foundHi | foundLo;
    grantId    = foundHi ? hiId : loId;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grantId) begin
        selKey         = req_key[i*128 +: 128];
        selPt          = req_pt[i*128 +: 128];
        grantOneHot[i] = grantFound;
      end
    end
  end

  assign rrNext    = (grantId == ID_W'(N_REQ - 1)) ? '0 : grantId + 1'b1;
  assign timerDone = (timer == TMR_LAST);
  assign byteIdx   = 4'd15 - cnt[3:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantFound) stateNext = LOAD;
      LOAD:    if (cnt == LOAD_LAST) stateNext = WAIT;
      WAIT: begin
        if (core_ready)     stateNext = UNLOAD;
        else if (timerDone) stateNext = RESP;
      end
      UNLOAD:  if (cnt == UNLOAD_LAST) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered outputs; byte 0 of each 128-bit word sits in [127:120].
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr           <= '0;
      keyLat          <= '0;
      ptLat           <= '0;
      cnt             <= '0;
      timer           <= '0;
      req_ready       <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_ct          <= '0;
      rsp_err         <= 1'b0;
      core_en         <= 1'b0;
      core_key_byte   <= '0;
      core_state_byte <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (grantFound) begin
            keyLat    <= selKey;
            ptLat     <= selPt;
            rsp_id    <= grantId;
            req_ready <= grantOneHot;
            rrPtr     <= rrNext;
            core_en   <= 1'b1;
            cnt       <= '0;
          end
        end
        LOAD: begin
          if (cnt == LOAD_LAST) begin
            cnt             <= '0;
            timer           <= '0;
            core_key_byte   <= '0;
            core_state_byte <= '0;
          end else begin
            cnt             <= cnt + 5'd1;
            core_key_byte   <= keyLat[{byteIdx, 3'b000} +: 8];
            core_state_byte <= ptLat[{byteIdx, 3'b000} +: 8];
          end
        end
        WAIT: begin
          if (core_ready) begin
            cnt <= '0;
          end else if (timerDone) begin
            core_en   <= 1'b0;
            rsp_ct    <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        UNLOAD: begin
          rsp_ct[{byteIdx, 3'b000} +: 8] <= core_out_byte;
          cnt <= cnt + 5'd1;
          if (cnt == UNLOAD_LAST) begin
            cnt       <= '0;
            core_en   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
